mem_port_arbiter: RTL and testbench

- Shares the CPU's single 16-bit memory port (readM/writeM/address/data) between two requesters: the instruction-fetch path (I) and the load/store data path (D).
- Sequences each access through a fixed-latency memory handshake and returns read data with a one-cycle valid pulse.
- Sits between the multicycle control/datapath and the external memory, so the control FSM no longer drives the memory pins directly.

---
 rtl/mem_port_arbiter_if.sv | 29 ++
 rtl/mem_port_arbiter.sv | 166 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 307 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// Requester-side bundle of mem_port_arbiter: the instruction-fetch (i_*)
// and load/store (d_*) request/response signals.
interface mem_port_arbiter_if #(
  parameter int WORD_SIZE = 16
);
  // Handshake: a requester raises *_req (level) with stable address/data and
  // holds it until the arbiter answers with a one-cycle *_valid pulse; the
  // request fields are only sampled on the cycle the arbiter grants it.
  logic                 i_req;
  logic [WORD_SIZE-1:0] i_addr;
  logic [WORD_SIZE-1:0] i_rdata;
  logic                 i_valid;
  logic                 d_req;
  logic                 d_we;
  logic [WORD_SIZE-1:0] d_addr;
  logic [WORD_SIZE-1:0] d_wdata;
  logic [WORD_SIZE-1:0] d_rdata;
  logic                 d_valid;

  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata,
    input  i_rdata, i_valid, d_rdata, d_valid
  );

  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata,
    output i_rdata, i_valid, d_rdata, d_valid
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one fixed-latency memory port between the fetch (I) and load/store (D)
// paths. Optional macro ARB_ROUND_ROBIN_EN selects round-robin on conflicts.
module mem_port_arbiter #(
  parameter int MEM_LATENCY = 2,
  parameter int WORD_SIZE   = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  mem_port_arbiter_if.slave    req_if,
  output logic                 readM,
  output logic                 writeM,
  output logic [WORD_SIZE-1:0] address,
  inout  wire  [WORD_SIZE-1:0] data,
  output logic                 busy,
  output logic [15:0]          conflict_cnt,
  output logic [1:0]           o_state
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  localparam logic       OWN_I    = 1'b0;
  localparam logic       OWN_D    = 1'b1;
  localparam logic [3:0] CNT_LOAD = 4'(MEM_LATENCY - 1);

  state_t               r_state;
  state_t               w_next;
  logic                 r_owner;
  logic                 r_we;
  logic [3:0]           r_cnt;
  logic [WORD_SIZE-1:0] r_addr;
  logic [WORD_SIZE-1:0] r_wdata;
  logic [WORD_SIZE-1:0] r_i_rdata;
  logic [WORD_SIZE-1:0] r_d_rdata;
  logic [15:0]          r_conflict_cnt;

  logic w_any_req;
  logic w_both_req;
  logic w_grant_d;
  logic w_cnt_zero;
  logic w_read;
  logic w_write;
  logic w_busy;
  logic w_i_valid;
  logic w_d_valid;
  logic w_drive_data;

  assign w_any_req  = req_if.i_req | req_if.d_req;
  assign w_both_req = req_if.i_req & req_if.d_req;
  assign w_cnt_zero = (r_cnt == 4'd0);

`ifdef ARB_ROUND_ROBIN_EN
  // On a conflict the requester not served last wins; resets to I so D goes first.
  logic r_last_grant;

  assign w_grant_d = req_if.d_req & (~req_if.i_req | (r_last_grant == OWN_I));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_last_grant <= OWN_I;
    end else if (r_state == S_IDLE && w_any_req) begin
      r_last_grant <= w_grant_d;
    end
  end
`else
  // D before I so the current instruction's load/store finishes before the next fetch.
  assign w_grant_d = req_if.d_req;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (w_any_req) w_next = S_ACCESS;
      S_ACCESS: if (w_cnt_zero) w_next = S_DONE;
      S_DONE:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_read       = 1'b0;
    w_write      = 1'b0;
    w_busy       = 1'b0;
    w_i_valid    = 1'b0;
    w_d_valid    = 1'b0;
    w_drive_data = 1'b0;
    case (r_state)
      S_ACCESS: begin
        w_busy       = 1'b1;
        w_read       = ~r_we;
        w_write      = r_we;
        w_drive_data = r_we;
      end
      S_DONE: begin
        w_busy    = 1'b1;
        w_i_valid = (r_owner == OWN_I);
        w_d_valid = (r_owner == OWN_D);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_owner        <= OWN_I;
      r_we           <= 1'b0;
      r_cnt          <= 4'd0;
      r_addr         <= '0;
      r_wdata        <= '0;
      r_i_rdata      <= '0;
      r_d_rdata      <= '0;
      r_conflict_cnt <= 16'd0;
    end else begin
      if (r_state == S_IDLE) begin
        if (w_both_req) begin
          r_conflict_cnt <= r_conflict_cnt + 16'd1;
        end
        if (w_any_req) begin
          r_owner <= w_grant_d;
          r_addr  <= w_grant_d ? req_if.d_addr : req_if.i_addr;
          r_we    <= w_grant_d & req_if.d_we;
          r_wdata <= req_if.d_wdata;
          r_cnt   <= CNT_LOAD;
        end
      end
      if (r_state == S_ACCESS) begin
        if (w_cnt_zero) begin
          // A store must leave d_rdata untouched, so only reads capture.
          if (!r_we) begin
            if (r_owner == OWN_D) begin
              r_d_rdata <= data;
            end else begin
              r_i_rdata <= data;
            end
          end
        end else begin
          r_cnt <= r_cnt - 4'd1;
        end
      end
    end
  end

  assign data           = w_drive_data ? r_wdata : {WORD_SIZE{1'bz}};
  assign readM          = w_read;
  assign writeM         = w_write;
  assign busy           = w_busy;
  assign address        = r_addr;
  assign conflict_cnt   = r_conflict_cnt;
  assign o_state        = r_state;
  assign req_if.i_rdata = r_i_rdata;
  assign req_if.d_rdata = r_d_rdata;
  assign req_if.i_valid = w_i_valid;
  assign req_if.d_valid = w_d_valid;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: a small memory model on the port, and a scoreboard
// of expected {owner, rdata} per completed access.
module tb_mem_port_arbiter;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         readM;
  logic         writeM;
  logic [W-1:0] address;
  wire  [W-1:0] data;
  logic         busy;
  logic [15:0]  conflict_cnt;
  logic [1:0]   o_state;

  int tests_run = 0;
  int tests_failed = 0;

  logic [16:0] exp_q[$];
  logic [16:0] mon_e;
  logic [W-1:0] mem [0:255];

  mem_port_arbiter_if #(.WORD_SIZE(W)) req_if();

  mem_port_arbiter #(.MEM_LATENCY(2), .WORD_SIZE(W)) dut (
    .clk          (clk),
    .reset        (reset),
    .req_if       (req_if.slave),
    .readM        (readM),
    .writeM       (writeM),
    .address      (address),
    .data         (data),
    .busy         (busy),
    .conflict_cnt (conflict_cnt),
    .o_state      (o_state)
  );

  // clock / memory model
  always #5 clk = ~clk;

  assign data = readM ? mem[address[7:0]] : {W{1'bz}};

  always @(posedge clk) begin
    if (writeM) mem[address[7:0]] <= data;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_reqs();
    req_if.i_req   = 1'b0;
    req_if.i_addr  = '0;
    req_if.d_req   = 1'b0;
    req_if.d_we    = 1'b0;
    req_if.d_addr  = '0;
    req_if.d_wdata = '0;
  endtask

  task automatic do_reset();
    clear_reqs();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // scoreboard: every valid pulse consumes one expected {is_d, rdata}
  always @(negedge clk) begin
    if (!reset) begin
      if (readM && writeM) check("strobe_exclusive", 32'd1, 32'd0);
      if (req_if.i_valid || req_if.d_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_valid", {30'd0, req_if.i_valid, req_if.d_valid}, 32'd0);
        end else begin
          mon_e = exp_q.pop_front();
          check("valid_owner", {30'd0, req_if.i_valid, req_if.d_valid},
                mon_e[16] ? 32'd1 : 32'd2);
          check("valid_rdata", mon_e[16] ? {16'd0, req_if.d_rdata} : {16'd0, req_if.i_rdata},
                {16'd0, mon_e[15:0]});
        end
      end
    end
  end

  initial begin
    int n;
    int di;
    int ii;
    int cnt_base;
    int cnt_inc;

    for (int i = 0; i < 256; i++) mem[i] = '0;
    mem[8'h10] = 16'h6A01;
    mem[8'h30] = 16'h1234;
    mem[8'h40] = 16'hAAAA;
    mem[8'h50] = 16'h5555;

    do_reset();
    check("rst_busy",    {31'd0, busy}, 32'd0);
    check("rst_readM",   {31'd0, readM}, 32'd0);
    check("rst_writeM",  {31'd0, writeM}, 32'd0);
    check("rst_address", {16'd0, address}, 32'd0);
    check("rst_cnt",     {16'd0, conflict_cnt}, 32'd0);
    check("rst_i_rdata", {16'd0, req_if.i_rdata}, 32'd0);
    check("rst_d_rdata", {16'd0, req_if.d_rdata}, 32'd0);
    check("rst_valids",  {30'd0, req_if.i_valid, req_if.d_valid}, 32'd0);
    check("rst_state",   {30'd0, o_state}, 32'd0);

    // single fetch
    req_if.i_addr = 16'h0010;
    req_if.i_req  = 1'b1;
    exp_q.push_back({1'b0, 16'h6A01});
    tick();
    check("fetch_c1_readM",  {31'd0, readM}, 32'd1);
    check("fetch_c1_writeM", {31'd0, writeM}, 32'd0);
    check("fetch_c1_addr",   {16'd0, address}, 32'h0010);
    req_if.i_addr = 16'h00FF;
    tick();
    check("fetch_c2_readM", {31'd0, readM}, 32'd1);
    check("fetch_c2_addr",  {16'd0, address}, 32'h0010);
    tick();
    check("fetch_c3_ivalid", {31'd0, req_if.i_valid}, 32'd1);
    check("fetch_c3_readM",  {31'd0, readM}, 32'd0);
    check("fetch_c3_rdata",  {16'd0, req_if.i_rdata}, 32'h6A01);
    req_if.i_req = 1'b0;
    tick();
    check("fetch_c4_busy",   {31'd0, busy}, 32'd0);
    check("fetch_c4_ivalid", {31'd0, req_if.i_valid}, 32'd0);

    // store, with wdata/we changing mid-access
    req_if.d_addr  = 16'h0020;
    req_if.d_wdata = 16'hBEEF;
    req_if.d_we    = 1'b1;
    req_if.d_req   = 1'b1;
    exp_q.push_back({1'b1, 16'h0000});
    tick();
    check("store_c1_writeM", {31'd0, writeM}, 32'd1);
    check("store_c1_readM",  {31'd0, readM}, 32'd0);
    check("store_c1_data",   {16'd0, data}, 32'hBEEF);
    req_if.d_wdata = 16'h0000;
    req_if.d_we    = 1'b0;
    tick();
    check("store_c2_writeM", {31'd0, writeM}, 32'd1);
    check("store_c2_data",   {16'd0, data}, 32'hBEEF);
    tick();
    check("store_c3_dvalid", {31'd0, req_if.d_valid}, 32'd1);
    check("store_c3_writeM", {31'd0, writeM}, 32'd0);
    req_if.d_req = 1'b0;
    tick();
    check("store_mem", {16'd0, mem[8'h20]}, 32'hBEEF);

    // conflict: D served first, then I
    do_reset();
    req_if.i_addr = 16'h0010;
    req_if.i_req  = 1'b1;
    req_if.d_addr = 16'h0030;
    req_if.d_we   = 1'b0;
    req_if.d_req  = 1'b1;
    exp_q.push_back({1'b1, 16'h1234});
    exp_q.push_back({1'b0, 16'h6A01});
    tick();
    tick();
    tick();
    check("conf_c3_dvalid", {31'd0, req_if.d_valid}, 32'd1);
    check("conf_c3_ivalid", {31'd0, req_if.i_valid}, 32'd0);
    check("conf_c3_drdata", {16'd0, req_if.d_rdata}, 32'h1234);
    req_if.d_req = 1'b0;
    tick();
    check("conf_c4_busy", {31'd0, busy}, 32'd0);
    tick();
    check("conf_c5_addr", {16'd0, address}, 32'h0010);
    tick();
    tick();
    check("conf_c7_ivalid", {31'd0, req_if.i_valid}, 32'd1);
    req_if.i_req = 1'b0;
    check("conf_cnt", {16'd0, conflict_cnt}, 32'd1);
    tick();

    // both held for four accesses, each requester drops after two services
    cnt_base = int'(conflict_cnt);
    req_if.i_addr = 16'h0050;
    req_if.d_addr = 16'h0040;
    req_if.d_we   = 1'b0;
    req_if.i_req  = 1'b1;
    req_if.d_req  = 1'b1;
`ifdef ARB_ROUND_ROBIN_EN
    exp_q.push_back({1'b1, 16'hAAAA});
    exp_q.push_back({1'b0, 16'h5555});
    exp_q.push_back({1'b1, 16'hAAAA});
    exp_q.push_back({1'b0, 16'h5555});
    cnt_inc = 3;
`else
    exp_q.push_back({1'b1, 16'hAAAA});
    exp_q.push_back({1'b1, 16'hAAAA});
    exp_q.push_back({1'b0, 16'h5555});
    exp_q.push_back({1'b0, 16'h5555});
    cnt_inc = 2;
`endif
    n = 0;
    di = 0;
    ii = 0;
    while ((di < 2 || ii < 2) && n < 40) begin
      tick();
      n++;
      if (req_if.d_valid) begin
        di++;
        if (di == 2) req_if.d_req = 1'b0;
      end
      if (req_if.i_valid) begin
        ii++;
        if (ii == 2) req_if.i_req = 1'b0;
      end
    end
    check("four_done", {30'd0, (di == 2), (ii == 2)}, 32'd3);
    check("four_cnt", {16'd0, conflict_cnt}, 32'(cnt_base + cnt_inc));
    clear_reqs();
    tick();

    // reset in the middle of a fetch
    req_if.i_addr = 16'h0010;
    req_if.i_req  = 1'b1;
    tick();
    check("rma_c1_readM", {31'd0, readM}, 32'd1);
    tick();
    reset = 1'b1;
    req_if.i_req = 1'b0;
    tick();
    check("rma_c3_readM",   {31'd0, readM}, 32'd0);
    check("rma_c3_busy",    {31'd0, busy}, 32'd0);
    check("rma_c3_ivalid",  {31'd0, req_if.i_valid}, 32'd0);
    check("rma_c3_i_rdata", {16'd0, req_if.i_rdata}, 32'd0);
    reset = 1'b0;
    repeat (5) tick();
    check("rma_idle_busy", {31'd0, busy}, 32'd0);
    req_if.i_addr = 16'h0050;
    req_if.i_req  = 1'b1;
    exp_q.push_back({1'b0, 16'h5555});
    tick();
    tick();
    tick();
    check("rma_refetch_ivalid", {31'd0, req_if.i_valid}, 32'd1);
    req_if.i_req = 1'b0;
    tick();

    // conflict counter wrap
    force dut.r_conflict_cnt = 16'hFFFF;
    tick();
    release dut.r_conflict_cnt;
    tick();
    check("wrap_preload", {16'd0, conflict_cnt}, 32'h0000FFFF);
    req_if.i_addr = 16'h0010;
    req_if.d_addr = 16'h0030;
    req_if.d_we   = 1'b0;
    req_if.i_req  = 1'b1;
    req_if.d_req  = 1'b1;
    exp_q.push_back({1'b1, 16'h1234});
    exp_q.push_back({1'b0, 16'h6A01});
    tick();
    check("wrap_cnt", {16'd0, conflict_cnt}, 32'd0);
    tick();
    tick();
    check("wrap_c3_dvalid", {31'd0, req_if.d_valid}, 32'd1);
    req_if.d_req = 1'b0;
    repeat (4) tick();
    check("wrap_c7_ivalid", {31'd0, req_if.i_valid}, 32'd1);
    req_if.i_req = 1'b0;
    tick();

    // a store leaves d_rdata at its last loaded value
    req_if.d_addr  = 16'h0060;
    req_if.d_wdata = 16'h7777;
    req_if.d_we    = 1'b1;
    req_if.d_req   = 1'b1;
    exp_q.push_back({1'b1, 16'h1234});
    tick();
    tick();
    tick();
    check("st2_dvalid", {31'd0, req_if.d_valid}, 32'd1);
    clear_reqs();
    tick();
    check("st2_mem",     {16'd0, mem[8'h60]}, 32'h7777);
    check("st2_d_rdata", {16'd0, req_if.d_rdata}, 32'h1234);

    repeat (2) tick();
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
